// File: rtl/stencil_stream_ctrl.sv
// stencil_stream_ctrl
//   Frame sequencer between an input memory, a stencil core and a downstream
//   consumer.  On start it latches the stencil weights, streams INPUT_NO beats
//   from memory into the core (throttled by output-FIFO headroom), collects
//   the core's output beats into an output FIFO, and finishes once OUTPUT_NO
//   beats have drained or the drain watchdog expires.
//
// Ports
//   clock          single clock
//   reset          asynchronous reset, active-low
//   start          pulse that begins a frame (honoured only when idle)
//   cfg_weight     stencil weights, latched on start
//   mem_rd_en      input-memory read strobe
//   mem_rd_addr    input-memory read address
//   mem_rd_data    read data, valid one cycle after mem_rd_en
//   st_in_ready    beat-valid to the stencil core
//   st_in_matrix   beat data to the core
//   st_in_weight   latched weights to the core
//   st_out_valid   core output beat valid (no backpressure possible)
//   st_out_data    core output beat
//   out_valid      downstream beat valid (FIFO non-empty)
//   out_data       downstream beat (FIFO head)
//   out_ready      downstream accept
//   busy           frame in progress (FEED or DRAIN)
//   done           one-cycle end-of-frame pulse
//   err_ovf        sticky output-FIFO overflow
//   err_tmo        sticky drain timeout
module stencil_stream_ctrl #(
  parameter int unsigned ST         = 2,
  parameter int unsigned BW         = 32,
  parameter int unsigned POINTS     = 7,
  parameter int unsigned INPUT_NO   = 19,
  parameter int unsigned OUTPUT_NO  = 8,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SKID       = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [POINTS*BW-1:0]   cfg_weight,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_rd_addr,
  input  logic [ST*BW-1:0]       mem_rd_data,
  output logic                   st_in_ready,
  output logic [ST*BW-1:0]       st_in_matrix,
  output logic [POINTS*BW-1:0]   st_in_weight,
  input  logic                   st_out_valid,
  input  logic [ST*BW-1:0]       st_out_data,
  output logic                   out_valid,
  output logic [ST*BW-1:0]       out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err_ovf,
  output logic                   err_tmo
);

  localparam int unsigned DW = ST * BW;
  localparam int unsigned IW = $clog2(INPUT_NO + 1);
  localparam int unsigned OW = $clog2(OUTPUT_NO + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [IW-1:0] IN_LAST  = IW'(INPUT_NO - 1);
  localparam logic [OW-1:0] OUT_TERM = OW'(OUTPUT_NO);
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WD_TERM  = TW'(TIMEOUT);
  localparam logic [CW-1:0] FIFO_CAP = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   in_cnt;
  logic [OW-1:0]   out_cnt;
  logic [TW-1:0]   wd_cnt;

  logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt;

  logic            frame_start;
  logic            rd_ok;
  logic            rd_fire;
  logic            tmo_hit;
  logic            flush;
  logic            capture;
  logic            fifo_full;
  logic            pop;
  logic            push;

  assign frame_start = (state == S_IDLE) && start;

  // Reads are only issued while the FIFO keeps more than SKID free slots, so
  // the beats already in flight through memory and core always fit.
  assign rd_ok     = (FIFO_DEPTH - 32'(fifo_cnt)) > SKID;

  assign fifo_full = (fifo_cnt == FIFO_CAP);
  assign out_valid = (fifo_cnt != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;

  // Core beats are taken in every state but IDLE; a full FIFO still accepts
  // when the head leaves in the same cycle.
  assign capture   = st_out_valid && (state != S_IDLE);
  assign push      = capture && (!fifo_full || pop);

  // Leftover FIFO contents are discarded on the way into DONE.
  assign flush     = (state == S_DRAIN) && (state_nxt == S_DONE);

  always_comb begin
    state_nxt = state;
    rd_fire   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FEED;
      end
      S_FEED: begin
        if (rd_ok) begin
          rd_fire = 1'b1;
          if (in_cnt == IN_LAST) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((out_cnt == OUT_TERM) && (fifo_cnt == '0)) begin
          state_nxt = S_DONE;
        end else if (!st_out_valid && (wd_cnt == WD_LAST)) begin
          tmo_hit   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_rd_en    = rd_fire;
  assign mem_rd_addr  = rd_fire ? ADDR_W'(in_cnt) : '0;
  assign st_in_matrix = st_in_ready ? mem_rd_data : '0;
  assign busy         = (state == S_FEED) || (state == S_DRAIN);
  assign done         = (state == S_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_cnt       <= '0;
      st_in_weight <= '0;
      st_in_ready  <= 1'b0;
    end else begin
      st_in_ready <= rd_fire;
      if (frame_start) begin
        in_cnt       <= '0;
        st_in_weight <= cfg_weight;
      end else if (rd_fire) begin
        in_cnt <= in_cnt + IW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_cnt <= '0;
    end else if (frame_start) begin
      out_cnt <= '0;
    end else if (capture && (out_cnt != OUT_TERM)) begin
      out_cnt <= out_cnt + OW'(1);
    end
  end

  // Watchdog counts DRAIN cycles without a core beat; it rests at zero
  // outside DRAIN so every drain phase starts with a full budget.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if ((state != S_DRAIN) || st_out_valid) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_TERM) begin
      wd_cnt <= wd_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_ovf <= 1'b0;
      err_tmo <= 1'b0;
    end else if (frame_start) begin
      err_ovf <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      if (capture && fifo_full && !pop) err_ovf <= 1'b1;
      if (tmo_hit) err_tmo <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: out_data is gated by out_valid.
  always_ff @(posedge clock) begin
    if (push && !flush) fifo_mem[wr_ptr] <= st_out_data;
  end

endmodule

// File: tb/tb_stencil_stream_ctrl.sv
module tb_stencil_stream_ctrl;

  localparam logic [63:0] MASK = 64'h0F0F_F0F0_0F0F_F0F0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [223:0]  cfg_weight = '0;
  logic          mem_rd_en;
  logic [4:0]    mem_rd_addr;
  logic [63:0]   mem_rd_data = '0;
  logic          st_in_ready;
  logic [63:0]   st_in_matrix;
  logic [223:0]  st_in_weight;
  logic          st_out_valid = 1'b0;
  logic [63:0]   st_out_data = '0;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          out_ready = 1'b1;
  logic          busy, done, err_ovf, err_tmo;

  logic          o_start = 1'b0;
  logic [223:0]  o_cfg_weight = '0;
  logic          o_mem_rd_en;
  logic [4:0]    o_mem_rd_addr;
  logic [63:0]   o_mem_rd_data = '0;
  logic          o_st_in_ready;
  logic [63:0]   o_st_in_matrix;
  logic [223:0]  o_st_in_weight;
  logic          o_st_out_valid = 1'b0;
  logic [63:0]   o_st_out_data = '0;
  logic          o_out_valid;
  logic [63:0]   o_out_data;
  logic          o_out_ready = 1'b0;
  logic          o_busy, o_done, o_err_ovf, o_err_tmo;

  always #5 clock = ~clock;

  stencil_stream_ctrl u_dut (
    .clock(clock), .reset(reset), .start(start), .cfg_weight(cfg_weight),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .st_in_ready(st_in_ready), .st_in_matrix(st_in_matrix), .st_in_weight(st_in_weight),
    .st_out_valid(st_out_valid), .st_out_data(st_out_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err_ovf(err_ovf), .err_tmo(err_tmo)
  );

  stencil_stream_ctrl #(.FIFO_DEPTH(4), .SKID(0)) u_ovf (
    .clock(clock), .reset(reset), .start(o_start), .cfg_weight(o_cfg_weight),
    .mem_rd_en(o_mem_rd_en), .mem_rd_addr(o_mem_rd_addr), .mem_rd_data(o_mem_rd_data),
    .st_in_ready(o_st_in_ready), .st_in_matrix(o_st_in_matrix), .st_in_weight(o_st_in_weight),
    .st_out_valid(o_st_out_valid), .st_out_data(o_st_out_data),
    .out_valid(o_out_valid), .out_data(o_out_data), .out_ready(o_out_ready),
    .busy(o_busy), .done(o_done), .err_ovf(o_err_ovf), .err_tmo(o_err_tmo)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int done_cnt = 0;
  int core_mode = 0;
  bit core_clr = 1'b0;
  int core_seen = 0;

  int          rd_addrs[$];
  int          rd_cyc[$];
  logic [63:0] in_data[$];
  int          rdy_cyc[$];
  logic [63:0] outq[$];

  function automatic logic [63:0] memf(input int a);
    return {32'hA5A5_0000 + 32'(a), 32'h0000_1000 + 32'(a * 3)};
  endfunction

  function automatic logic [223:0] mkw(input logic [31:0] seed);
    logic [223:0] w;
    for (int i = 0; i < 7; i++) w[i*32 +: 32] = seed + 32'(i) * 32'h0101;
    return w;
  endfunction

  // Core model: mode 0 emits after input beats 12..19, mode 1 after every
  // beat, mode 2 after beats 15..19, mode 3 never.
  function automatic bit emit(input int mode, input int n);
    case (mode)
      0: return n >= 12;
      1: return 1'b1;
      2: return n >= 15;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (mem_rd_en === 1'b1) mem_rd_data <= memf(int'(mem_rd_addr));
  end

  always @(posedge clock) begin
    st_out_valid <= 1'b0;
    if (core_clr) begin
      core_seen <= 0;
    end else if (st_in_ready === 1'b1) begin
      core_seen <= core_seen + 1;
      if (emit(core_mode, core_seen + 1)) begin
        st_out_valid <= 1'b1;
        st_out_data  <= st_in_matrix ^ MASK;
      end
    end
  end

  always @(negedge clock) begin
    if (mem_rd_en === 1'b1) begin
      rd_addrs.push_back(int'(mem_rd_addr));
      rd_cyc.push_back(cyc);
    end
    if (st_in_ready === 1'b1) begin
      in_data.push_back(st_in_matrix);
      rdy_cyc.push_back(cyc);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) outq.push_back(out_data);
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input bit clr);
    start = 1'b1;
    core_clr = clr;
    tick(1);
    start = 1'b0;
    core_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    chk(tag, 256'(done), 256'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int b_rd, b_rdy, b_out, b_done, bad, since, beats, n;
    logic [223:0] w1, w2, w3;
    w1 = mkw(32'h1111_0000);
    w2 = mkw(32'h2222_0000);
    w3 = mkw(32'h3333_0000);

    // Reset: start and weights presented while in reset must not register.
    cfg_weight = w1;
    o_cfg_weight = w3;
    start = 1'b1;
    tick(3);
    start = 1'b0;
    chk("rst_outs", 256'({mem_rd_en, mem_rd_addr, st_in_ready, st_in_matrix, out_valid,
                          out_data, busy, done, err_ovf, err_tmo}), 256'(0));
    chk("rst_weight", 256'(st_in_weight), 256'(0));
    chk("rst_ovf_outs", 256'({o_mem_rd_en, o_mem_rd_addr, o_st_in_ready, o_st_in_matrix,
                              o_out_valid, o_out_data, o_busy, o_done, o_err_ovf,
                              o_err_tmo}), 256'(0));
    chk("rst_ovf_weight", 256'(o_st_in_weight), 256'(0));
    reset = 1'b1;
    tick(2);
    chk("idle_busy", 256'(busy), 256'(0));

    // Nominal frame.
    core_mode = 0;
    out_ready = 1'b1;
    b_rd = rd_addrs.size(); b_rdy = rdy_cyc.size(); b_out = outq.size(); b_done = done_cnt;
    do_start(1'b1);
    chk("nom_busy", 256'(busy), 256'(1));
    wait_done("nom_done_seen", 200);
    tick(2);
    chk("nom_rd_count", 256'(rd_addrs.size() - b_rd), 256'(19));
    bad = 0;
    for (int i = 0; i < 19; i++) if (rd_addrs[b_rd+i] != i) bad++;
    chk("nom_rd_order", 256'(bad), 256'(0));
    chk("nom_rd_b2b", 256'(rd_cyc[b_rd+18] - rd_cyc[b_rd]), 256'(18));
    chk("nom_rdy_count", 256'(rdy_cyc.size() - b_rdy), 256'(19));
    chk("nom_rdy_lat", 256'(rdy_cyc[b_rdy] - rd_cyc[b_rd]), 256'(1));
    chk("nom_rdy_b2b", 256'(rdy_cyc[b_rdy+18] - rdy_cyc[b_rdy]), 256'(18));
    bad = 0;
    for (int i = 0; i < 19; i++) if (in_data[b_rdy+i] !== memf(i)) bad++;
    chk("nom_matrix", 256'(bad), 256'(0));
    chk("nom_out_count", 256'(outq.size() - b_out), 256'(8));
    for (int j = 0; j < 8; j++)
      chk($sformatf("nom_out%0d", j), 256'(outq[b_out+j]), 256'(memf(11 + j) ^ MASK));
    chk("nom_done_pulses", 256'(done_cnt - b_done), 256'(1));
    chk("nom_busy_after", 256'({busy, done}), 256'(0));
    chk("nom_weight", 256'(st_in_weight), 256'(w1));
    chk("nom_errs", 256'({err_ovf, err_tmo}), 256'(0));

    // Backpressure: one output per input, consumer stalled.
    core_mode = 1;
    out_ready = 1'b0;
    b_rd = rd_addrs.size(); b_out = outq.size(); b_done = done_cnt;
    do_start(1'b1);
    tick(40);
    chk("bp_rd_stall", 256'(rd_addrs.size() - b_rd), 256'(10));
    chk("bp_head", 256'({out_valid, out_data}), 256'({1'b1, memf(0) ^ MASK}));
    chk("bp_busy", 256'(busy), 256'(1));
    chk("bp_no_ovf", 256'(err_ovf), 256'(0));
    out_ready = 1'b1;
    wait_done("bp_done_seen", 400);
    tick(2);
    chk("bp_rd_count", 256'(rd_addrs.size() - b_rd), 256'(19));
    chk("bp_out_count", 256'(outq.size() - b_out), 256'(19));
    bad = 0;
    for (int j = 0; j < 19; j++) if (outq[b_out+j] !== (memf(j) ^ MASK)) bad++;
    chk("bp_out_order", 256'(bad), 256'(0));
    chk("bp_done_pulses", 256'(done_cnt - b_done), 256'(1));
    chk("bp_errs", 256'({err_ovf, err_tmo}), 256'(0));

    // Timeout: only 5 of 8 beats.
    core_mode = 2;
    b_out = outq.size();
    do_start(1'b1);
    since = 0; beats = 0; n = 0;
    while (err_tmo !== 1'b1 && n < 300) begin
      bit v;
      v = st_out_valid;
      tick(1);
      n++;
      if (v) begin beats++; since = 0; end
      else since++;
    end
    chk("tmo_flag", 256'(err_tmo), 256'(1));
    chk("tmo_beats", 256'(beats), 256'(5));
    chk("tmo_latency", 256'(since), 256'(64));
    chk("tmo_done", 256'(done), 256'(1));
    tick(2);
    chk("tmo_out_count", 256'(outq.size() - b_out), 256'(5));
    for (int j = 0; j < 5; j++)
      chk($sformatf("tmo_out%0d", j), 256'(outq[b_out+j]), 256'(memf(14 + j) ^ MASK));

    // Reset in the middle of FEED.
    core_mode = 3;
    b_done = done_cnt;
    do_start(1'b1);
    n = 0;
    while (!(mem_rd_en === 1'b1 && mem_rd_addr === 5'd10) && n < 60) begin
      tick(1);
      n++;
    end
    chk("mid_rd_addr10", 256'({mem_rd_en, mem_rd_addr}), 256'({1'b1, 5'd10}));
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", 256'({mem_rd_en, mem_rd_addr, st_in_ready, st_in_matrix, out_valid,
                              out_data, busy, done, err_ovf, err_tmo}), 256'(0));
    chk("mid_rst_weight", 256'(st_in_weight), 256'(0));
    tick(3);
    chk("mid_rst_hold", 256'({mem_rd_en, st_in_ready, busy, done}), 256'(0));
    reset = 1'b1;
    tick(3);
    chk("mid_no_done", 256'(done_cnt - b_done), 256'(0));

    // Clean frame after reset, with ignored starts in FEED and DRAIN.
    core_mode = 0;
    cfg_weight = w2;
    b_rd = rd_addrs.size(); b_out = outq.size(); b_done = done_cnt;
    do_start(1'b1);
    tick(5);
    cfg_weight = w3;
    do_start(1'b0);
    tick(13);
    chk("ign_busy_drain", 256'(busy), 256'(1));
    do_start(1'b0);
    wait_done("ign_done_seen", 100);
    tick(2);
    chk("ign_first_addr", 256'(rd_addrs[b_rd]), 256'(0));
    chk("ign_rd_count", 256'(rd_addrs.size() - b_rd), 256'(19));
    bad = 0;
    for (int i = 0; i < 19; i++) if (rd_addrs[b_rd+i] != i) bad++;
    chk("ign_rd_order", 256'(bad), 256'(0));
    chk("ign_weight", 256'(st_in_weight), 256'(w2));
    chk("ign_out_count", 256'(outq.size() - b_out), 256'(8));
    chk("ign_out_last", 256'(outq[b_out+7]), 256'(memf(18) ^ MASK));
    chk("ign_done_pulses", 256'(done_cnt - b_done), 256'(1));

    // Overflow on the 4-deep, zero-reserve instance.
    o_out_ready = 1'b0;
    o_start = 1'b1;
    tick(1);
    o_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      o_st_out_valid = 1'b1;
      o_st_out_data = 64'hD000_0000_0000_0000 + 64'(k);
      tick(1);
    end
    o_st_out_valid = 1'b0;
    tick(1);
    chk("ovf_flag", 256'(o_err_ovf), 256'(1));
    chk("ovf_head", 256'({o_out_valid, o_out_data}), 256'({1'b1, 64'hD000_0000_0000_0000}));
    chk("ovf_busy", 256'(o_busy), 256'(1));
    o_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("ovf_out%0d", j), 256'({o_out_valid, o_out_data}),
          256'({1'b1, 64'hD000_0000_0000_0000 + 64'(j)}));
      tick(1);
    end
    chk("ovf_dropped", 256'(o_out_valid), 256'(0));
    n = 0;
    while (o_done !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    chk("ovf_done_seen", 256'(o_done), 256'(1));
    chk("ovf_errs_end", 256'({o_err_ovf, o_err_tmo}), 256'(2'b11));
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
